l1a_align_checker: RTL and testbench

Parametrised successor to the 16-ADC L1A checker. It walks a configurable number of ADC channels in order and confirms that every enabled channel reports the same L1A counter value for the current trigger. Results go out as registered per-channel error flags, a per-channel done pulse and an end-of-round alignment pulse. The block sits between the per-ADC L1A capture logic and the SFP status/readout path. It adds three things the fixed version lacks: channel masking, a per-channel timeout, and comparison against one reference value captured per round.

---
 rtl/l1a_align_checker.sv | 198 +++++++++++++++++++
 tb/tb_l1a_align_checker.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l1a_align_checker.sv
// l1a_align_checker
//   Walks N_CH ADC channels in index order and confirms that every unmasked
//   channel reports the same L1A counter value for the current trigger. The
//   first unmasked channel of a round supplies the reference value. Later
//   channels are compared against that reference. Each channel has a wait
//   timeout. All outputs are registered.
//
//   Optional feature: define L1A_MISMATCH_CNT_EN to build the saturating
//   16-bit mismatch counter. Without it, mismatch_cnt is tied to 0.
module l1a_align_checker #(
    parameter int N_CH  = 16,
    parameter int L1A_W = 14,
    parameter int TMO_W = 16,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH*L1A_W-1:0] l1a_bus,
    input  logic [N_CH-1:0]       trig_in,
    input  logic [N_CH-1:0]       start_check,
    input  logic                  check_in_progress,
    input  logic [N_CH-1:0]       ch_mask,
    input  logic [TMO_W-1:0]      tmo_limit,
    input  logic                  clear_err,
    output logic                  l1a_align,
    output logic [N_CH-1:0]       error,
    output logic [N_CH-1:0]       tmo_err,
    output logic                  one_ch_done,
    output logic                  busy,
    output logic [CH_W-1:0]       cur_ch,
    output logic [15:0]           mismatch_cnt
);

    logic [CH_W-1:0]  cur_ch_q,      cur_ch_d;
    logic             busy_q,        busy_d;
    logic [L1A_W-1:0] ref_q,         ref_d;
    logic [TMO_W-1:0] wait_q,        wait_d;
    logic             fail_q,        fail_d;
    logic [N_CH-1:0]  error_q,       error_d;
    logic [N_CH-1:0]  tmo_err_q,     tmo_err_d;
    logic             one_ch_done_q, one_ch_done_d;
    logic             l1a_align_q,   l1a_align_d;
    logic             mm_inc;

    logic [L1A_W-1:0] l1a_ch [N_CH];
    logic [N_CH-1:0]  above_unmasked;
    logic             strobe;
    logic             is_last;
    logic             advance;
    logic [L1A_W-1:0] cur_l1a;

    // Unpack the L1A bus and flag unmasked channels above the pointer.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign l1a_ch[gi]         = l1a_bus[gi*L1A_W +: L1A_W];
        assign above_unmasked[gi] = !ch_mask[gi] && (CH_W'(gi) > cur_ch_q);
    end

    assign cur_l1a = l1a_ch[cur_ch_q];
    assign strobe  = trig_in[cur_ch_q] & start_check[cur_ch_q];
    // Current channel is the last one of the round when no unmasked channel follows it.
    assign is_last = ~|above_unmasked;

    // Per-channel scan, compare, timeout and round bookkeeping.
    always_comb begin
        cur_ch_d      = cur_ch_q;
        busy_d        = busy_q;
        ref_d         = ref_q;
        wait_d        = wait_q;
        fail_d        = fail_q;
        error_d       = clear_err ? '0 : error_q;
        tmo_err_d     = clear_err ? '0 : tmo_err_q;
        one_ch_done_d = 1'b0;
        l1a_align_d   = 1'b0;
        mm_inc        = 1'b0;
        advance       = 1'b0;

        if (ch_mask[cur_ch_q]) begin
            // Masked channel: spend one cycle and move on.
            if (cur_ch_q == CH_W'(N_CH - 1)) begin
                cur_ch_d = '0;
                busy_d   = 1'b0;
                fail_d   = 1'b0;
            end else begin
                cur_ch_d = cur_ch_q + CH_W'(1);
            end
            wait_d = '0;
        end else if (!busy_q) begin
            // First channel of a round. The timeout is not armed here, so an
            // idle link does not keep raising errors.
            if (strobe) begin
                if (check_in_progress) begin
                    ref_d              = cur_l1a;
                    error_d[cur_ch_q]  = 1'b0;
                    one_ch_done_d      = 1'b1;
                    busy_d             = 1'b1;
                    fail_d             = 1'b0;
                    advance            = 1'b1;
                end else begin
                    error_d[cur_ch_q]  = 1'b1;
                end
            end
        end else begin
            if (strobe && (cur_l1a == ref_q)) begin
                error_d[cur_ch_q] = 1'b0;
                one_ch_done_d     = 1'b1;
                advance           = 1'b1;
            end else begin
                if (strobe) begin
                    error_d[cur_ch_q] = 1'b1;
                    mm_inc            = 1'b1;
                end
                if ((tmo_limit != '0) && (wait_q == tmo_limit)) begin
                    error_d[cur_ch_q]   = 1'b1;
                    tmo_err_d[cur_ch_q] = 1'b1;
                    fail_d              = 1'b1;
                    advance             = 1'b1;
                end else begin
                    wait_d = wait_q + TMO_W'(1);
                end
            end
        end

        error_d = error_d & ~ch_mask;

        if (advance) begin
            wait_d = '0;
            if (is_last) begin
                // Alignment requires a clean error vector and no timeout anywhere this round.
                l1a_align_d = one_ch_done_d && !fail_d && !(|error_d);
                cur_ch_d    = '0;
                busy_d      = 1'b0;
                fail_d      = 1'b0;
            end else begin
                cur_ch_d = cur_ch_q + CH_W'(1);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_ch_q      <= '0;
            busy_q        <= 1'b0;
            ref_q         <= '0;
            wait_q        <= '0;
            fail_q        <= 1'b0;
            error_q       <= '0;
            tmo_err_q     <= '0;
            one_ch_done_q <= 1'b0;
            l1a_align_q   <= 1'b0;
        end else begin
            cur_ch_q      <= cur_ch_d;
            busy_q        <= busy_d;
            ref_q         <= ref_d;
            wait_q        <= wait_d;
            fail_q        <= fail_d;
            error_q       <= error_d;
            tmo_err_q     <= tmo_err_d;
            one_ch_done_q <= one_ch_done_d;
            l1a_align_q   <= l1a_align_d;
        end
    end

    assign cur_ch      = cur_ch_q;
    assign busy        = busy_q;
    assign error       = error_q;
    assign tmo_err     = tmo_err_q;
    assign one_ch_done = one_ch_done_q;
    assign l1a_align   = l1a_align_q;

`ifdef L1A_MISMATCH_CNT_EN
    logic [15:0] mismatch_cnt_q, mismatch_cnt_d;

    // Saturating count of failed compares. An increment in the same cycle as clear_err wins.
    always_comb begin
        mismatch_cnt_d = clear_err ? 16'h0000 : mismatch_cnt_q;
        if (mm_inc && (mismatch_cnt_d != 16'hFFFF)) begin
            mismatch_cnt_d = mismatch_cnt_d + 16'h0001;
        end
    end

    // Mismatch counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mismatch_cnt_q <= 16'h0000;
        end else begin
            mismatch_cnt_q <= mismatch_cnt_d;
        end
    end

    assign mismatch_cnt = mismatch_cnt_q;
`else
    logic unused_mm_inc;
    assign unused_mm_inc = mm_inc;
    assign mismatch_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_l1a_align_checker.sv
// Directed testbench for l1a_align_checker with N_CH=4.
// Inputs are driven 1 time unit after the rising edge. Outputs are checked
// at the same point, which is after the edge that registered them.
module tb_l1a_align_checker;

    localparam int N_CH  = 4;
    localparam int L1A_W = 14;
    localparam int TMO_W = 16;

    logic                  clk;
    logic                  reset;
    logic [N_CH*L1A_W-1:0] l1a_bus;
    logic [N_CH-1:0]       trig_in;
    logic [N_CH-1:0]       start_check;
    logic                  check_in_progress;
    logic [N_CH-1:0]       ch_mask;
    logic [TMO_W-1:0]      tmo_limit;
    logic                  clear_err;
    logic                  l1a_align;
    logic [N_CH-1:0]       error;
    logic [N_CH-1:0]       tmo_err;
    logic                  one_ch_done;
    logic                  busy;
    logic [1:0]            cur_ch;
    logic [15:0]           mismatch_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_mm3;

    l1a_align_checker #(.N_CH(N_CH), .L1A_W(L1A_W), .TMO_W(TMO_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .l1a_bus           (l1a_bus),
        .trig_in           (trig_in),
        .start_check       (start_check),
        .check_in_progress (check_in_progress),
        .ch_mask           (ch_mask),
        .tmo_limit         (tmo_limit),
        .clear_err         (clear_err),
        .l1a_align         (l1a_align),
        .error             (error),
        .tmo_err           (tmo_err),
        .one_ch_done       (one_ch_done),
        .busy              (busy),
        .cur_ch            (cur_ch),
        .mismatch_cnt      (mismatch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Time-limit guard: the run should finish far sooner than this.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_l1a(input int ch, input logic [L1A_W-1:0] v);
        l1a_bus[ch*L1A_W +: L1A_W] = v;
    endtask

    // Apply a trigger vector for one clock, then report the registered response.
    task automatic go(input logic [N_CH-1:0] trig, input string what);
        trig_in = trig;
        @(posedge clk);
        #1;
        $display("%0t %-14s trig=%b cur_ch=%0d done=%0b align=%0b busy=%0b err=%b tmo=%b mm=%0d",
                 $time, what, trig, cur_ch, one_ch_done, l1a_align, busy, error, tmo_err, mismatch_cnt);
    endtask

    initial begin
`ifdef L1A_MISMATCH_CNT_EN
        exp_mm3 = 3;
`else
        exp_mm3 = 0;
`endif
        reset             = 1'b0;
        trig_in           = '0;
        start_check       = 4'hF;
        check_in_progress = 1'b1;
        ch_mask           = '0;
        tmo_limit         = '0;
        clear_err         = 1'b0;
        for (int i = 0; i < N_CH; i++) set_l1a(i, 14'h123);

        // Reset state
        #3;
        check("rst_align", l1a_align, 0);
        check("rst_error", error, 0);
        check("rst_tmo", tmo_err, 0);
        check("rst_done", one_ch_done, 0);
        check("rst_busy", busy, 0);
        check("rst_cur", cur_ch, 0);
        check("rst_mm", mismatch_cnt, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 1: clean round, every channel at 0x123
        go(4'b0001, "r1 ch0");
        check("r1c0_done", one_ch_done, 1);
        check("r1c0_cur", cur_ch, 1);
        check("r1c0_busy", busy, 1);
        check("r1c0_align", l1a_align, 0);
        go(4'b0010, "r1 ch1");
        check("r1c1_done", one_ch_done, 1);
        check("r1c1_cur", cur_ch, 2);
        go(4'b0100, "r1 ch2");
        check("r1c2_done", one_ch_done, 1);
        check("r1c2_cur", cur_ch, 3);
        go(4'b1000, "r1 ch3");
        check("r1c3_done", one_ch_done, 1);
        check("r1c3_align", l1a_align, 1);
        check("r1c3_busy", busy, 0);
        check("r1c3_cur", cur_ch, 0);
        check("r1c3_err", error, 0);
        go(4'b0000, "r1 idle");
        check("r1_done_pulse", one_ch_done, 0);
        check("r1_align_pulse", l1a_align, 0);

        // 2: channel 2 disagrees, then is corrected
        set_l1a(2, 14'h124);
        go(4'b0001, "r2 ch0");
        go(4'b0010, "r2 ch1");
        go(4'b0100, "r2 ch2 bad");
        check("r2_err_set", error, 4'b0100);
        check("r2_stay", cur_ch, 2);
        check("r2_nodone", one_ch_done, 0);
        set_l1a(2, 14'h123);
        go(4'b0100, "r2 ch2 fixed");
        check("r2_err_clr", error, 0);
        check("r2_fix_done", one_ch_done, 1);
        check("r2_fix_cur", cur_ch, 3);
        go(4'b1000, "r2 ch3");
        check("r2_align", l1a_align, 1);

        // 3: channels 0 and 1 masked, reference from channel 2
        ch_mask = 4'b0011;
        set_l1a(2, 14'h055);
        set_l1a(3, 14'h055);
        go(4'b0011, "r3 skip0");
        check("r3_skip0_cur", cur_ch, 1);
        check("r3_skip0_done", one_ch_done, 0);
        go(4'b0011, "r3 skip1");
        check("r3_skip1_cur", cur_ch, 2);
        check("r3_skip1_done", one_ch_done, 0);
        go(4'b0100, "r3 ch2");
        check("r3_c2_done", one_ch_done, 1);
        check("r3_c2_busy", busy, 1);
        go(4'b1000, "r3 ch3");
        check("r3_align", l1a_align, 1);
        check("r3_cur", cur_ch, 0);
        check("r3_err", error, 0);
        ch_mask = '0;
        for (int i = 0; i < N_CH; i++) set_l1a(i, 14'h123);

        // 4: channel 1 never strobes, timeout of 5 wait cycles
        tmo_limit = 16'd5;
        go(4'b0001, "r4 ch0");
        for (int i = 0; i < 5; i++) go(4'b0000, "r4 wait");
        check("r4_pre_cur", cur_ch, 1);
        check("r4_pre_tmo", tmo_err, 0);
        go(4'b0000, "r4 timeout");
        check("r4_tmo", tmo_err, 4'b0010);
        check("r4_err", error, 4'b0010);
        check("r4_cur", cur_ch, 2);
        check("r4_nodone", one_ch_done, 0);
        go(4'b0100, "r4 ch2");
        go(4'b1000, "r4 ch3");
        check("r4_last_done", one_ch_done, 1);
        check("r4_align", l1a_align, 0);
        check("r4_busy", busy, 0);
        tmo_limit = '0;
        clear_err = 1'b1;
        go(4'b0000, "r4 clear");
        clear_err = 1'b0;
        check("r4_clr_tmo", tmo_err, 0);
        check("r4_clr_err", error, 0);

        // 5: first channel without check_in_progress, then clear vs set
        check_in_progress = 1'b0;
        go(4'b0001, "r5 no cip");
        check("r5_err", error, 4'b0001);
        check("r5_cur", cur_ch, 0);
        check("r5_busy", busy, 0);
        clear_err = 1'b1;
        go(4'b0001, "r5 clr+set");
        check("r5_set_wins", error, 4'b0001);
        go(4'b0000, "r5 clr");
        check("r5_cleared", error, 0);
        clear_err = 1'b0;
        check_in_progress = 1'b1;

        // 6: reset mid-round while on channel 3
        go(4'b0001, "r6 ch0");
        go(4'b0010, "r6 ch1");
        go(4'b0100, "r6 ch2");
        check("r6_cur3", cur_ch, 3);
        #2;
        reset = 1'b0;
        #1;
        check("r6_rst_cur", cur_ch, 0);
        check("r6_rst_busy", busy, 0);
        check("r6_rst_done", one_ch_done, 0);
        check("r6_rst_err", error, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 7: three mismatches on channel 1, then clear_err
        set_l1a(1, 14'h124);
        go(4'b0001, "r7 ch0");
        check("r7_restart_done", one_ch_done, 1);
        for (int i = 0; i < 3; i++) go(4'b0010, "r7 ch1 bad");
        check("r7_mm3", mismatch_cnt, exp_mm3);
        check("r7_err", error, 4'b0010);
        check("r7_cur", cur_ch, 1);
        clear_err = 1'b1;
        go(4'b0000, "r7 clear");
        clear_err = 1'b0;
        check("r7_mm0", mismatch_cnt, 0);
        check("r7_err_clr", error, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
